// File: rtl/flash_cmd_seq.sv
// Command-phase sequencer for the serial flash slave: decodes the opcode as it is
// captured, then steps through address, dummy and data phases driving phase enables.
module flash_cmd_seq #(
    parameter int DUMMY_CYC = 8
) (
    input  logic        sck,
    input  logic        rst,
    input  logic        cs_n,
    input  logic        mode,
    input  logic [7:0]  op_in,
    input  logic [7:0]  op,
    output logic        en_opcode,
    output logic [23:0] addr,
    output logic        addr_valid,
    output logic [2:0]  cmd_class,
    output logic        dummy_active,
    output logic        data_in_en,
    output logic        data_out_en,
    output logic        illegal,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] OPCODE = 3'd1;
    localparam logic [2:0] ADDR   = 3'd2;
    localparam logic [2:0] DUMMY  = 3'd3;
    localparam logic [2:0] DATA   = 3'd4;
    localparam logic [2:0] HOLD   = 3'd5;

    localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_CYC - 1);

    logic [2:0] state;
    logic [4:0] cnt;
    logic [7:0] nxt_op;
    logic [2:0] nxt_class;
    logic       opcode_done;
    logic       addr_done;

    function automatic logic [2:0] decode_op(input logic [7:0] o);
        case (o)
            8'h03:   decode_op = 3'd1;
            8'h0B:   decode_op = 3'd2;
            8'h02:   decode_op = 3'd3;
            8'h20:   decode_op = 3'd4;
            8'h06:   decode_op = 3'd5;
            8'h05:   decode_op = 3'd6;
            8'h9F:   decode_op = 3'd7;
            default: decode_op = 3'd0;
        endcase
    endfunction

    // nxt_op matches what the opcode stage latches on this same edge.
    always_comb begin
        nxt_op      = mode ? op_in : {op[6:0], op_in[0]};
        nxt_class   = decode_op(nxt_op);
        opcode_done = (state == IDLE && mode) || (state == OPCODE && cnt == 5'd7);
        addr_done   = (state == ADDR) && (cnt == (mode ? 5'd2 : 5'd23));
    end

    assign en_opcode = !cs_n && !rst && (state == IDLE || state == OPCODE);
    assign dbg_state = state;

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            addr         <= '0;
            cmd_class    <= '0;
            addr_valid   <= 1'b0;
            illegal      <= 1'b0;
            dummy_active <= 1'b0;
            data_in_en   <= 1'b0;
            data_out_en  <= 1'b0;
        end else if (cs_n) begin
            // addr and cmd_class survive deselect; everything else clears.
            state        <= IDLE;
            cnt          <= '0;
            addr_valid   <= 1'b0;
            illegal      <= 1'b0;
            dummy_active <= 1'b0;
            data_in_en   <= 1'b0;
            data_out_en  <= 1'b0;
        end else begin
            addr_valid <= 1'b0;
            if (opcode_done) begin
                cmd_class <= nxt_class;
                cnt       <= '0;
                case (nxt_class)
                    3'd1, 3'd2, 3'd3, 3'd4: state <= ADDR;
                    3'd6, 3'd7: begin
                        state       <= DATA;
                        data_out_en <= 1'b1;
                    end
                    3'd0: begin
                        state   <= HOLD;
                        illegal <= 1'b1;
                    end
                    default: state <= HOLD;
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        state <= OPCODE;
                        cnt   <= 5'd1;
                    end
                    OPCODE: cnt <= cnt + 5'd1;
                    ADDR: begin
                        addr <= mode ? {addr[15:0], op_in} : {addr[22:0], op_in[0]};
                        if (addr_done) begin
                            addr_valid <= 1'b1;
                            cnt        <= '0;
                            case (cmd_class)
                                3'd1: begin
                                    state       <= DATA;
                                    data_out_en <= 1'b1;
                                end
                                3'd2: begin
                                    state        <= DUMMY;
                                    dummy_active <= 1'b1;
                                end
                                3'd3: begin
                                    state      <= DATA;
                                    data_in_en <= 1'b1;
                                end
                                default: state <= HOLD;
                            endcase
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                    DUMMY: begin
                        if (cnt == DUMMY_LAST) begin
                            state        <= DATA;
                            dummy_active <= 1'b0;
                            data_out_en  <= 1'b1;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flash_cmd_seq.sv
// Self-checking bench for flash_cmd_seq: directed frames plus randomized frames
// checked edge by edge against a phase-timeline model of the command protocol.
module tb_flash_cmd_seq;

    localparam int DUMMY_CYC = 8;

    logic        sck = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1;
    logic        mode = 1'b0;
    logic [7:0]  op_in = 8'h00;
    logic [7:0]  op;
    logic        en_opcode;
    logic [23:0] addr;
    logic        addr_valid;
    logic [2:0]  cmd_class;
    logic        dummy_active;
    logic        data_in_en;
    logic        data_out_en;
    logic        illegal;
    logic [2:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    logic [2:0]  exp_class = 3'd0;
    logic [23:0] exp_addr = 24'd0;

    flash_cmd_seq #(.DUMMY_CYC(DUMMY_CYC)) dut (
        .sck(sck), .rst(rst), .cs_n(cs_n), .mode(mode), .op_in(op_in), .op(op),
        .en_opcode(en_opcode), .addr(addr), .addr_valid(addr_valid),
        .cmd_class(cmd_class), .dummy_active(dummy_active), .data_in_en(data_in_en),
        .data_out_en(data_out_en), .illegal(illegal), .dbg_state(dbg_state)
    );

    always #5 sck = ~sck;

    // Opcode capture stage upstream of the DUT.
    always_ff @(posedge sck or posedge rst) begin
        if (rst) op <= 8'h00;
        else if (en_opcode) op <= mode ? op_in : {op[6:0], op_in[0]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cls_of(input logic [7:0] o);
        case (o)
            8'h03: return 1;
            8'h0B: return 2;
            8'h02: return 3;
            8'h20: return 4;
            8'h06: return 5;
            8'h05: return 6;
            8'h9F: return 7;
            default: return 0;
        endcase
    endfunction

    // Drives n_edges sck edges of a frame with cs_n low and checks every edge.
    task automatic run_frame(input logic m, input logic [7:0] opc, input logic [23:0] a,
                             input int n_edges);
        int  len_op, len_addr, c, ds, k;
        bit  has_addr, dout, din;
        len_op   = m ? 1 : 8;
        len_addr = m ? 3 : 24;
        c        = cls_of(opc);
        has_addr = (c >= 1 && c <= 4);
        dout     = (c == 1 || c == 2 || c == 6 || c == 7);
        din      = (c == 3);
        ds       = len_op + (has_addr ? len_addr : 0) + (c == 2 ? DUMMY_CYC : 0);
        for (int e = 1; e <= n_edges; e++) begin
            cs_n  = 1'b0;
            mode  = m;
            op_in = 8'($urandom);
            if (e <= len_op) begin
                if (m) op_in = opc;
                else op_in[0] = opc[8-e];
            end else if (has_addr && e <= len_op + len_addr) begin
                k = e - len_op;
                if (m) op_in = a[8*(3-k) +: 8];
                else op_in[0] = a[24-k];
            end
            #1;
            check("en_opcode", 32'(en_opcode), 32'(e <= len_op));
            @(posedge sck);
            #1;
            if (e == len_op) exp_class = 3'(c);
            if (has_addr && e > len_op && e <= len_op + len_addr)
                exp_addr = m ? {exp_addr[15:0], op_in} : {exp_addr[22:0], op_in[0]};
            check("cmd_class", 32'(cmd_class), 32'(exp_class));
            check("addr", 32'(addr), 32'(exp_addr));
            check("addr_valid", 32'(addr_valid), 32'(has_addr && e == len_op + len_addr));
            check("dummy_active", 32'(dummy_active),
                  32'(c == 2 && e >= len_op + len_addr && e < len_op + len_addr + DUMMY_CYC));
            check("data_out_en", 32'(data_out_en), 32'(dout && e >= ds));
            check("data_in_en", 32'(data_in_en), 32'(din && e >= ds));
            check("illegal", 32'(illegal), 32'(c == 0 && e >= len_op));
        end
    endtask

    task automatic end_frame();
        cs_n  = 1'b1;
        op_in = 8'($urandom);
        #1;
        check("en_opcode_csn", 32'(en_opcode), 32'd0);
        @(posedge sck);
        #1;
        check("end_addr_valid", 32'(addr_valid), 32'd0);
        check("end_illegal", 32'(illegal), 32'd0);
        check("end_dummy", 32'(dummy_active), 32'd0);
        check("end_data_in", 32'(data_in_en), 32'd0);
        check("end_data_out", 32'(data_out_en), 32'd0);
        check("end_cmd_class", 32'(cmd_class), 32'(exp_class));
        check("end_addr", 32'(addr), 32'(exp_addr));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en_opcode"}, 32'(en_opcode), 32'd0);
        check({tag, "_addr"}, 32'(addr), 32'd0);
        check({tag, "_addr_valid"}, 32'(addr_valid), 32'd0);
        check({tag, "_cmd_class"}, 32'(cmd_class), 32'd0);
        check({tag, "_dummy"}, 32'(dummy_active), 32'd0);
        check({tag, "_data_in"}, 32'(data_in_en), 32'd0);
        check({tag, "_data_out"}, 32'(data_out_en), 32'd0);
        check({tag, "_illegal"}, 32'(illegal), 32'd0);
    endtask

    initial begin
        logic [7:0] opc_tbl [8];
        logic [7:0] opc;
        int         n;
        opc_tbl = '{8'h03, 8'h0B, 8'h02, 8'h20, 8'h06, 8'h05, 8'h9F, 8'h00};

        // Reset state, with cs_n low to show en_opcode is gated by rst.
        cs_n = 1'b0;
        #12;
        check_all_zero("reset");
        cs_n = 1'b1;
        #11;
        rst = 1'b0;
        @(posedge sck);
        #1;

        // SPI READ 0x123456
        run_frame(1'b0, 8'h03, 24'h123456, 40);
        end_frame();
        // OPI FAST_READ 0xABCDEF
        run_frame(1'b1, 8'h0B, 24'hABCDEF, 16);
        end_frame();
        // SPI WREN followed by 16 ignored edges
        run_frame(1'b0, 8'h06, 24'h000000, 24);
        end_frame();
        // OPI illegal opcode, further edges must not touch addr
        run_frame(1'b1, 8'h55, 24'($urandom), 10);
        end_frame();
        // SPI PP aborted after 10 address edges
        run_frame(1'b0, 8'h02, 24'($urandom), 18);
        end_frame();
        // SPI RDID
        run_frame(1'b0, 8'h9F, 24'h000000, 12);
        end_frame();

        // Randomized frames, some aborted at arbitrary points.
        for (int i = 0; i < 30; i++) begin
            opc = opc_tbl[$urandom_range(0, 7)];
            if (opc == 8'h00) opc = 8'($urandom);
            n = $urandom_range(1, 50);
            run_frame(1'($urandom_range(0, 1)), opc, 24'($urandom), n);
            end_frame();
        end

        // Asynchronous reset in the middle of the dummy phase.
        run_frame(1'b1, 8'h0B, 24'h5A5A5A, 7);
        check("pre_rst_dummy", 32'(dummy_active), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        exp_class = 3'd0;
        exp_addr  = 24'd0;
        cs_n = 1'b1;
        #3;
        rst = 1'b0;
        @(posedge sck);
        #1;
        run_frame(1'b1, 8'h05, 24'h000000, 4);
        end_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/flash_cmd_seq.md
Name: flash_cmd_seq

Overview:
- Command-phase sequencer that sits directly downstream of the opcode capture stage in the serial flash slave.
- Generates en_opcode to drive that stage.
- Takes the same pin bus plus the opcode stage's op output and decodes the command class as the last opcode edge is captured.
- Then walks the address, dummy and data phases, collecting a 24-bit address and driving the phase enables used by the array and data-path stages.

Parameters:
- DUMMY_CYC, 8, number of dummy sck edges for FAST_READ (range 1..31).

Ports:
- sck  input  1  serial clock; all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- cs_n  input  1  chip select, active low, sampled on posedge sck.
- mode  input  1  0 = SPI (1 bit per edge on bit 0), 1 = OPI (8 bits per edge).
- op_in  input  8  pin bus, shared with the opcode stage.
- op  input  8  registered opcode from the opcode stage.
- en_opcode  output  1  opcode-stage enable (combinational).
- addr  output  24  captured address, MSB first.
- addr_valid  output  1  one-cycle pulse when the address is complete.
- cmd_class  output  3  registered decoded command.
- dummy_active  output  1  high during dummy edges.
- data_in_en  output  1  data-in phase (program).
- data_out_en  output  1  data-out phase (reads/status/ID).
- illegal  output  1  unknown opcode latched; held until cs_n high.

Behaviour:
- Async reset (rst=1): state=IDLE, bit counter=0, addr=0, cmd_class=0, addr_valid=0, illegal=0, dummy_active=0, data_in_en=0, data_out_en=0. en_opcode=0 while rst=1.
- States: IDLE, OPCODE, ADDR, DUMMY, DATA, HOLD.
- cs_n=1 at any posedge: state returns to IDLE. addr_valid, illegal, dummy_active, data_in_en and data_out_en clear; addr and cmd_class are retained. This takes priority over all other transitions.
- en_opcode = !cs_n && !rst && (state==IDLE || state==OPCODE).
- IDLE with cs_n=0: the edge counts as opcode edge 1. Go to OPCODE with count=1, or decode immediately when mode=1.
- Opcode length: 8 edges in SPI, 1 edge in OPI.
- At the final opcode edge, nxt_op = mode ? op_in : {op[6:0], op_in[0]}. This is the same value the opcode stage latches on that edge. cmd_class is registered from nxt_op:
  - 0x03 READ: class 1, addr, then data out.
  - 0x0B FAST_READ: class 2, addr, DUMMY_CYC dummy edges, then data out.
  - 0x02 PP: class 3, addr, then data in.
  - 0x20 SE: class 4, addr, then HOLD.
  - 0x06 WREN: class 5, HOLD.
  - 0x05 RDSR: class 6, data out.
  - 0x9F RDID: class 7, data out.
  - any other value: class 0, illegal=1, HOLD.
- ADDR phase:
  - SPI: addr <= {addr[22:0], op_in[0]} for 24 edges.
  - OPI: addr <= {addr[15:0], op_in} for 3 edges.
  - Counter reset to 0 on entry.
  - The edge completing the address sets addr_valid=1 for exactly one sck cycle and moves to the next phase.
- DUMMY phase: dummy_active=1 for exactly DUMMY_CYC edges, then DATA. Dummy count is mode-independent.
- DATA phase: data_out_en or data_in_en (per class) stays high until cs_n=1. No internal termination; data wraps are owned downstream.
- HOLD: all enables low; sck edges are ignored until cs_n=1.
- Phase enables are registered. They assert from the edge that enters the phase, so they are valid for the first edge belonging to that phase.
- cs_n deasserted mid-opcode or mid-address: abort. addr_valid does not pulse and the partial addr value is retained; the next frame overwrites it.
- Mode is sampled per edge. Changing mode within a frame is unsupported; it must be stable while cs_n=0.

Test Plan:
- Reset, then SPI frame with cs_n low, opcode 0x03 serialised MSB first, address bits 0x123456 -> en_opcode high for 8 edges; cmd_class=1 after edge 8; addr_valid pulses on edge 32 with addr=0x123456; data_out_en=1 from edge 32 until cs_n rises.
- OPI frame, op_in=0x0B then 0xAB, 0xCD, 0xEF, DUMMY_CYC=8 -> cmd_class=2; addr=0xABCDEF with addr_valid on edge 4; dummy_active on edges 5..12; data_out_en from edge 12.
- SPI opcode 0x06, followed by 16 more edges -> cmd_class=5; no addr_valid; all enables 0; cs_n high returns to IDLE; the next frame's first edge asserts en_opcode.
- OPI opcode 0x55 -> illegal=1, cmd_class=0, HOLD; further edges leave addr unchanged; cs_n high clears illegal.
- SPI 0x02 aborted by cs_n high after 10 address edges -> no addr_valid, data_in_en never set, state IDLE. A new 0x9F frame gives cmd_class=7 and data_out_en after edge 8.
- rst pulsed asynchronously mid-DUMMY, between sck edges -> all outputs 0 immediately, with no sck edge required.
